// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core front end.
package cpu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IMM_W = 16;

   localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0000;
   localparam logic [XLEN-1:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC priority mux and wrapping +4 adder.
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            stall_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic            hold_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_c_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   assign pc_plus4_c_o = pc_q + XLEN'(4);
   assign pc_o         = pc_q;

   // Branch outranks jump; hold covers both the halted state and a fetched halt word.
   always_comb begin
      pc_d = pc_q;
      if (stall_i) begin
         pc_d = pc_q;
      end else if (branch_i) begin
         pc_d = branch_target_i;
      end else if (jump_i) begin
         pc_d = jump_target_i;
      end else if (hold_i) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4_c_o;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register with stall, flush,
// redirect and halt handling.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             jump,
   input  logic [XLEN-1:0]  jump_target,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic [XLEN-1:0]  if_id_instr,
   output logic [XLEN-1:0]  if_id_pc_plus4,
   output logic [IMM_W-1:0] if_id_imm16,
   output logic             if_id_valid,
   output logic             halted
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   if_id_t          if_id_q;
   if_id_t          if_id_d;
   logic [XLEN-1:0] pc_plus4_c;
   logic            in_run_c;
   logic            branch_c;
   logic            jump_c;
   logic            redirect_c;
   logic            pc_hold_c;
   logic            halt_take_c;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock_i         (clock),
      .reset_i         (reset),
      .stall_i         (stall),
      .branch_i        (branch_c),
      .branch_target_i (branch_target),
      .jump_i          (jump_c),
      .jump_target_i   (jump_target),
      .hold_i          (pc_hold_c),
      .pc_o            (imem_addr),
      .pc_plus4_c_o    (pc_plus4_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_RUN:    if (halt_take_c) state_d = FETCH_HALTED;
         FETCH_HALTED: state_d = FETCH_HALTED;
         default:      state_d = FETCH_RUN;
      endcase
   end

   // Redirects are ignored once halted; a halt word only counts on a clean fetch.
   always_comb begin
      in_run_c    = (state_q == FETCH_RUN);
      branch_c    = in_run_c & branch_taken;
      jump_c      = in_run_c & jump;
      redirect_c  = branch_c | jump_c;
      pc_hold_c   = ~in_run_c | (imem_rdata == HALT_INSTR);
      halt_take_c = in_run_c & (imem_rdata == HALT_INSTR) & ~stall & ~flush & ~redirect_c;
   end

   always_comb begin
      if_id_d = if_id_q;
      if (flush) begin
         if_id_d = IF_ID_BUBBLE;
      end else if (stall) begin
         if_id_d = if_id_q;
      end else if (redirect_c || !in_run_c) begin
         if_id_d = IF_ID_BUBBLE;
      end else begin
         if_id_d = '{instr: imem_rdata, pc_plus4: pc_plus4_c, valid: 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         if_id_q <= IF_ID_BUBBLE;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign if_id_instr    = if_id_q.instr;
   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_imm16    = if_id_q.instr[IMM_W-1:0];
   assign if_id_valid    = if_id_q.valid;
   assign halted         = (state_q == FETCH_HALTED);

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS core. It holds the program counter, drives the instruction-memory address, and handles stall, flush, branch/jump redirect and halt detection. It registers the fetched word into IF/ID, which feeds the decode stage. The decode stage takes `if_id_imm16` straight into the sign extender.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `stall` input 1: from the hazard unit; freezes the PC and the IF/ID register.
- `flush` input 1: replaces the next IF/ID contents with a bubble.
- `branch_taken` input 1: redirects the PC to `branch_target`.
- `branch_target` input 32: byte address.
- `jump` input 1: redirects the PC to `jump_target`.
- `jump_target` input 32: byte address.
- `imem_addr` output 32: equals the current PC.
- `imem_rdata` input 32: instruction at `imem_addr`; combinational read, valid in the same cycle.
- `if_id_instr` output 32: registered instruction.
- `if_id_pc_plus4` output 32: registered PC+4 of that instruction.
- `if_id_imm16` output 16: `if_id_instr[15:0]`; input to the sign extender.
- `if_id_valid` output 1: 0 means the IF/ID contents are a bubble.
- `halted` output 1: high once the halt instruction has been fetched.

## Operation
- State machine has two states, RUN and HALTED. Reset puts it in RUN.
- PC next-value priority, highest first:
  - reset → `RESET_PC`.
  - `stall` → hold.
  - `branch_taken` → `branch_target`. If both redirects are asserted, branch wins over jump.
  - `jump` → `jump_target`.
  - state HALTED → hold.
  - fetched word == `HALT_INSTR` → hold, and the state moves to HALTED.
  - otherwise → PC+4.
- PC+4 is a 32-bit add that wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Targets are loaded as given, with no alignment check.
- IF/ID register update priority, highest first:
  - reset → instr 0 (NOP), pc_plus4 0, valid 0.
  - `flush` → NOP, valid 0, pc_plus4 0. `flush` beats `stall`.
  - `stall` → hold all fields.
  - `branch_taken` or `jump` → NOP bubble, valid 0. The wrong-path word is discarded.
  - state HALTED → NOP bubble, valid 0.
  - otherwise → `imem_rdata`, PC+4, valid 1.
- Entering HALTED:
  - The halt word is passed into IF/ID exactly once, with valid 1.
  - `halted` rises in the same edge.
  - From then on, IF/ID carries only bubbles.
- A halt word fetched in a cycle with stall, flush or redirect does not enter HALTED:
  - Under stall, the same word is re-examined on the next cycle.
  - Under redirect or flush, it is on the wrong path and is dropped.
- HALTED is left only by reset. Redirect inputs are ignored in HALTED.
- A `reset` assertion mid-operation immediately (asynchronously) forces every register to its reset value.

## Timing
- Reset values:
  - `imem_addr` = `RESET_PC`.
  - `if_id_instr` = 0, `if_id_imm16` = 0, `if_id_pc_plus4` = 0, `if_id_valid` = 0.
  - `halted` = 0.
- Latency is 1 cycle. The word fetched at PC in cycle n appears on `if_id_*` after edge n+1.
- A redirect asserted in cycle n:
  - `imem_addr` = target in cycle n+1.
  - The target instruction is in IF/ID after edge n+2.
  - Exactly one bubble is inserted.
- `stall` for k cycles holds PC and IF/ID for k edges. There is no fetch duplication or loss.
- `imem_addr` is driven directly from the PC register, with no combinational path from the inputs.

## Structure
- Shared package `cpu_pkg` holds:
  - constants `NOP_INSTR` (32'h0), `HALT_INSTR_DEFAULT` and `RESET_PC_DEFAULT`;
  - the state enum `fetch_state_t` {FETCH_RUN, FETCH_HALTED}.
- One sub-module, `pc_reg`: PC register, next-PC priority mux and +4 adder.
- The IF/ID register and the state machine live in `if_id_stage`.

## Test plan
- Sequential fetch:
  - Stimulus: reset, then memory returns 32'h2008_0005 at addr 0 and 32'h2009_FFFF at addr 4.
  - Response: after edges 1 and 2, IF/ID = {2008_0005, pc_plus4 4, valid 1}, then {2009_FFFF, 8, 1}; `if_id_imm16` = 16'hFFFF.
- Stall then flush:
  - Stimulus: `stall` for 2 cycles at PC=8, then `flush` together with `stall`.
  - Response: PC held at 8 for 2 edges; IF/ID held, then NOP with valid 0.
- Redirect:
  - Stimulus: `branch_taken` with target 32'h40 at PC=0x10, with `jump` (target 0x80) asserted in the same cycle.
  - Response: next `imem_addr` = 0x40; one bubble; the instruction at 0x40 is in IF/ID 2 edges later.
- Halt:
  - Stimulus: memory returns 32'hFFFF_FFFF at 0x20.
  - Response: IF/ID gets the halt word with valid 1 and `halted` = 1 on that edge; then PC stays 0x20 and IF/ID shows only bubbles for 10 cycles.
- Halt under redirect:
  - Stimulus: halt word at 0x20 while `jump` to 0x100 is asserted.
  - Response: no halt; `imem_addr` = 0x100.
- Wrap and async reset:
  - Stimulus: redirect to 32'hFFFF_FFFC, then a normal fetch; later assert `reset` mid-cycle.
  - Response: PC wraps to 0. On reset, outputs return to reset values immediately, without waiting for a clock edge.
